// File: rtl/dlsc_pcie_s6_inbound_read_req_pkg.sv
// Shared definitions for the PCIe inbound read path: FSM states, max_payload
// encodings and the payload-size to DW conversion.
package dlsc_pcie_s6_inbound_read_req_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [2:0] MPS_128  = 3'd0;
    localparam logic [2:0] MPS_256  = 3'd1;
    localparam logic [2:0] MPS_512  = 3'd2;
    localparam logic [2:0] MPS_1024 = 3'd3;
    localparam logic [2:0] MPS_2048 = 3'd4;
    localparam logic [2:0] MPS_4096 = 3'd5;

    // Completion size in DW: encoded max_payload clipped to max_size bytes.
    // Reserved encodings (6,7) are treated as the largest size.
    function automatic logic [10:0] size_to_dw(input logic [2:0] mps, input int max_size);
        logic [10:0] dw;
        case (mps)
            MPS_128:  dw = 11'd32;
            MPS_256:  dw = 11'd64;
            MPS_512:  dw = 11'd128;
            MPS_1024: dw = 11'd256;
            MPS_2048: dw = 11'd512;
            default:  dw = 11'd1024;
        endcase
        if (int'(dw) > (max_size / 4)) begin
            dw = 11'(max_size / 4);
        end
        return dw;
    endfunction

endpackage

// File: rtl/dlsc_pcie_s6_bytecount.sv
// Byte count and leading-byte offset of a DW-granular PCIe request, derived
// from its length and first/last byte enables.
module dlsc_pcie_s6_bytecount (
    input  logic [10:0] len,
    input  logic [3:0]  be_first,
    input  logic [3:0]  be_last,
    output logic [12:0] bytes,
    output logic [1:0]  lead
);

    logic [3:0] be_end;
    logic [1:0] trail;

    always_comb begin
        // A single-DW request carries both ends in be_first.
        be_end = (len == 11'd1) ? be_first : be_last;

        casez (be_first)
            4'b???1: lead = 2'd0;
            4'b??10: lead = 2'd1;
            4'b?100: lead = 2'd2;
            4'b1000: lead = 2'd3;
            default: lead = 2'd0;
        endcase

        casez (be_end)
            4'b1???: trail = 2'd0;
            4'b01??: trail = 2'd1;
            4'b001?: trail = 2'd2;
            4'b0001: trail = 2'd3;
            default: trail = 2'd0;
        endcase

        if (len == 11'd1 && be_first == 4'd0) begin
            bytes = 13'd1;
        end else begin
            bytes = {len, 2'b00} - {11'd0, lead} - {11'd0, trail};
        end
    end

endmodule

// File: rtl/dlsc_pcie_s6_inbound_read_req.sv
// Turns one inbound MRd header at a time into AXI read bursts and a matching
// stream of CplD header descriptors; the two output streams run independently.
module dlsc_pcie_s6_inbound_read_req
    import dlsc_pcie_s6_inbound_read_req_pkg::*;
#(
    parameter int ADDR     = 32,
    parameter int LEN      = 4,
    parameter int MAX_SIZE = 128
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      max_payload,
    output logic            tlp_ready,
    input  logic            tlp_valid,
    input  logic [ADDR-3:0] tlp_addr,
    input  logic [9:0]      tlp_len,
    input  logic [3:0]      tlp_be_first,
    input  logic [3:0]      tlp_be_last,
    input  logic [7:0]      tlp_tag,
    input  logic [15:0]     tlp_src_id,
    input  logic [1:0]      tlp_attr,
    input  logic [2:0]      tlp_tc,
    input  logic            axi_ar_ready,
    output logic            axi_ar_valid,
    output logic [ADDR-1:0] axi_ar_addr,
    output logic [LEN-1:0]  axi_ar_len,
    input  logic            cpl_ready,
    output logic            cpl_valid,
    output logic [6:0]      cpl_addr_low,
    output logic [9:0]      cpl_len,
    output logic [11:0]     cpl_bytes,
    output logic            cpl_last,
    output logic [7:0]      cpl_tag,
    output logic [15:0]     cpl_src_id,
    output logic [1:0]      cpl_attr,
    output logic [2:0]      cpl_tc,
    output logic            dbg_busy
);

    localparam logic [10:0] BURST_MAX = 11'(2**LEN);

    state_t          state_q, state_d;
    logic            tlp_ready_q, tlp_ready_d;
    logic            ar_valid_q, ar_valid_d;
    logic [ADDR-3:0] ar_addr_q, ar_addr_d;
    logic [10:0]     ar_rem_q, ar_rem_d;
    logic            cpl_valid_q, cpl_valid_d;
    logic [9:0]      cpl_addr_q, cpl_addr_d;     // DW offset within the 4KB page
    logic [10:0]     cpl_rem_q, cpl_rem_d;
    logic [12:0]     cpl_bytes_q, cpl_bytes_d;
    logic            cpl_first_q, cpl_first_d;
    logic [1:0]      lead_q, lead_d;
    logic [10:0]     csz_dw_q, csz_dw_d;
    logic [7:0]      tag_q, tag_d;
    logic [15:0]     src_id_q, src_id_d;
    logic [1:0]      attr_q, attr_d;
    logic [2:0]      tc_q, tc_d;

    logic [10:0] req_len;
    logic [12:0] bc_bytes;
    logic [1:0]  bc_lead;
    logic [10:0] ar_to_4k, ar_burst;
    logic [10:0] cpl_to_bound, cpl_span;

    assign req_len = (tlp_len == 10'd0) ? 11'd1024 : {1'b0, tlp_len};

    dlsc_pcie_s6_bytecount u_bytecount (
        .len      (req_len),
        .be_first (tlp_be_first),
        .be_last  (tlp_be_last),
        .bytes    (bc_bytes),
        .lead     (bc_lead)
    );

    always_comb begin
        ar_to_4k = 11'd1024 - {1'b0, ar_addr_q[9:0]};
        ar_burst = ar_rem_q;
        if (ar_burst > BURST_MAX) ar_burst = BURST_MAX;
        if (ar_burst > ar_to_4k)  ar_burst = ar_to_4k;

        cpl_to_bound = csz_dw_q - ({1'b0, cpl_addr_q} & (csz_dw_q - 11'd1));
        cpl_span     = (cpl_rem_q < cpl_to_bound) ? cpl_rem_q : cpl_to_bound;
    end

    always_comb begin
        state_d     = state_q;
        ar_valid_d  = ar_valid_q;
        ar_addr_d   = ar_addr_q;
        ar_rem_d    = ar_rem_q;
        cpl_valid_d = cpl_valid_q;
        cpl_addr_d  = cpl_addr_q;
        cpl_rem_d   = cpl_rem_q;
        cpl_bytes_d = cpl_bytes_q;
        cpl_first_d = cpl_first_q;
        lead_d      = lead_q;
        csz_dw_d    = csz_dw_q;
        tag_d       = tag_q;
        src_id_d    = src_id_q;
        attr_d      = attr_q;
        tc_d        = tc_q;

        case (state_q)
            ST_IDLE: begin
                if (tlp_valid && tlp_ready_q) begin
                    state_d     = ST_BUSY;
                    ar_valid_d  = 1'b1;
                    ar_addr_d   = tlp_addr;
                    ar_rem_d    = req_len;
                    cpl_valid_d = 1'b1;
                    cpl_addr_d  = tlp_addr[9:0];
                    cpl_rem_d   = req_len;
                    cpl_bytes_d = bc_bytes;
                    cpl_first_d = 1'b1;
                    lead_d      = bc_lead;
                    csz_dw_d    = size_to_dw(max_payload, MAX_SIZE);
                    tag_d       = tlp_tag;
                    src_id_d    = tlp_src_id;
                    attr_d      = tlp_attr;
                    tc_d        = tlp_tc;
                end
            end
            default: begin
                if (ar_valid_q && axi_ar_ready) begin
                    ar_addr_d = ar_addr_q + {{(ADDR-13){1'b0}}, ar_burst};
                    ar_rem_d  = ar_rem_q - ar_burst;
                    if (ar_burst == ar_rem_q) ar_valid_d = 1'b0;
                end
                if (cpl_valid_q && cpl_ready) begin
                    cpl_addr_d  = cpl_addr_q + cpl_span[9:0];
                    cpl_rem_d   = cpl_rem_q - cpl_span;
                    // Only the first completion is shortened by the leading byte offset.
                    cpl_bytes_d = cpl_bytes_q - ({cpl_span, 2'b00} - {11'd0, (cpl_first_q ? lead_q : 2'b00)});
                    cpl_first_d = 1'b0;
                    if (cpl_span == cpl_rem_q) cpl_valid_d = 1'b0;
                end
                if (!ar_valid_d && !cpl_valid_d) state_d = ST_IDLE;
            end
        endcase

        tlp_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tlp_ready_q <= 1'b0;
            ar_valid_q  <= 1'b0;
            ar_addr_q   <= '0;
            ar_rem_q    <= '0;
            cpl_valid_q <= 1'b0;
            cpl_addr_q  <= '0;
            cpl_rem_q   <= '0;
            cpl_bytes_q <= '0;
            cpl_first_q <= 1'b0;
            lead_q      <= '0;
            csz_dw_q    <= '0;
            tag_q       <= '0;
            src_id_q    <= '0;
            attr_q      <= '0;
            tc_q        <= '0;
        end else begin
            state_q     <= state_d;
            tlp_ready_q <= tlp_ready_d;
            ar_valid_q  <= ar_valid_d;
            ar_addr_q   <= ar_addr_d;
            ar_rem_q    <= ar_rem_d;
            cpl_valid_q <= cpl_valid_d;
            cpl_addr_q  <= cpl_addr_d;
            cpl_rem_q   <= cpl_rem_d;
            cpl_bytes_q <= cpl_bytes_d;
            cpl_first_q <= cpl_first_d;
            lead_q      <= lead_d;
            csz_dw_q    <= csz_dw_d;
            tag_q       <= tag_d;
            src_id_q    <= src_id_d;
            attr_q      <= attr_d;
            tc_q        <= tc_d;
        end
    end

    assign tlp_ready    = tlp_ready_q;
    assign dbg_busy     = (state_q == ST_BUSY);
    assign axi_ar_valid = ar_valid_q;
    assign axi_ar_addr  = {ar_addr_q, 2'b00};
    assign axi_ar_len   = LEN'(ar_burst - 11'd1);
    assign cpl_valid    = cpl_valid_q;
    assign cpl_addr_low = {cpl_addr_q[4:0], (cpl_first_q ? lead_q : 2'b00)};
    assign cpl_len      = cpl_span[9:0];
    assign cpl_bytes    = cpl_bytes_q[11:0];
    assign cpl_last     = (cpl_rem_q == cpl_span);
    assign cpl_tag      = tag_q;
    assign cpl_src_id   = src_id_q;
    assign cpl_attr     = attr_q;
    assign cpl_tc       = tc_q;

endmodule

// File: tb/tb_dlsc_pcie_s6_inbound_read_req.sv
// Bench for dlsc_pcie_s6_inbound_read_req: a byte-level reference model fills
// expected AR and completion queues; negedge monitors score every handshake.
module tb_dlsc_pcie_s6_inbound_read_req;

    localparam int ADDR     = 32;
    localparam int LEN      = 4;
    localparam int MAX_SIZE = 512;
    localparam int AR_W     = ADDR + LEN;
    localparam int CPL_W    = 59;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [2:0]      max_payload = '0;
    logic            tlp_ready;
    logic            tlp_valid = 1'b0;
    logic [ADDR-3:0] tlp_addr = '0;
    logic [9:0]      tlp_len = '0;
    logic [3:0]      tlp_be_first = '0;
    logic [3:0]      tlp_be_last = '0;
    logic [7:0]      tlp_tag = '0;
    logic [15:0]     tlp_src_id = '0;
    logic [1:0]      tlp_attr = '0;
    logic [2:0]      tlp_tc = '0;
    logic            axi_ar_ready;
    logic            axi_ar_valid;
    logic [ADDR-1:0] axi_ar_addr;
    logic [LEN-1:0]  axi_ar_len;
    logic            cpl_ready;
    logic            cpl_valid;
    logic [6:0]      cpl_addr_low;
    logic [9:0]      cpl_len;
    logic [11:0]     cpl_bytes;
    logic            cpl_last;
    logic [7:0]      cpl_tag;
    logic [15:0]     cpl_src_id;
    logic [1:0]      cpl_attr;
    logic [2:0]      cpl_tc;
    logic            dbg_busy;

    logic [AR_W-1:0]  exp_ar_q[$];
    logic [CPL_W-1:0] exp_cpl_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // ready generation: forced level or random
    logic ar_rand = 1'b0, ar_force = 1'b0;
    logic cpl_rand = 1'b0, cpl_force = 1'b0;

    always #5 clk = ~clk;

    dlsc_pcie_s6_inbound_read_req #(
        .ADDR(ADDR), .LEN(LEN), .MAX_SIZE(MAX_SIZE)
    ) dut (
        .clk(clk), .rst(rst), .max_payload(max_payload),
        .tlp_ready(tlp_ready), .tlp_valid(tlp_valid), .tlp_addr(tlp_addr),
        .tlp_len(tlp_len), .tlp_be_first(tlp_be_first), .tlp_be_last(tlp_be_last),
        .tlp_tag(tlp_tag), .tlp_src_id(tlp_src_id), .tlp_attr(tlp_attr), .tlp_tc(tlp_tc),
        .axi_ar_ready(axi_ar_ready), .axi_ar_valid(axi_ar_valid),
        .axi_ar_addr(axi_ar_addr), .axi_ar_len(axi_ar_len),
        .cpl_ready(cpl_ready), .cpl_valid(cpl_valid), .cpl_addr_low(cpl_addr_low),
        .cpl_len(cpl_len), .cpl_bytes(cpl_bytes), .cpl_last(cpl_last),
        .cpl_tag(cpl_tag), .cpl_src_id(cpl_src_id), .cpl_attr(cpl_attr), .cpl_tc(cpl_tc),
        .dbg_busy(dbg_busy)
    );

    initial begin
        axi_ar_ready = 1'b0;
        cpl_ready    = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            axi_ar_ready = ar_rand ? ($urandom_range(0, 2) != 0) : ar_force;
            cpl_ready    = cpl_rand ? ($urandom_range(0, 2) != 0) : cpl_force;
        end
    end

    // AR scoreboard: stability while stalled, then compare on handshake
    initial begin
        logic [AR_W-1:0] cur, prev;
        logic pend;
        pend = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = {axi_ar_addr, axi_ar_len};
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    n_checks++;
                    if (axi_ar_valid !== 1'b1 || cur !== prev) begin
                        n_fail++;
                        $display("FAIL ar_hold: got valid=%b %h required valid=1 %h", axi_ar_valid, cur, prev);
                    end
                end
                if (axi_ar_valid && axi_ar_ready) begin
                    n_checks++;
                    if (exp_ar_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL ar_extra: got addr=%h len=%0d required no burst", axi_ar_addr, axi_ar_len);
                    end else begin
                        if (cur !== exp_ar_q[0]) begin
                            n_fail++;
                            $display("FAIL ar_burst: got addr=%h len=%0d required addr=%h len=%0d",
                                     axi_ar_addr, axi_ar_len, exp_ar_q[0][AR_W-1:LEN], exp_ar_q[0][LEN-1:0]);
                        end
                        void'(exp_ar_q.pop_front());
                    end
                end
                pend = axi_ar_valid && !axi_ar_ready;
                prev = cur;
            end
        end
    end

    // completion scoreboard
    initial begin
        logic [CPL_W-1:0] cur, prev;
        logic pend;
        pend = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = {cpl_addr_low, cpl_len, cpl_bytes, cpl_last, cpl_tag, cpl_src_id, cpl_attr, cpl_tc};
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    n_checks++;
                    if (cpl_valid !== 1'b1 || cur !== prev) begin
                        n_fail++;
                        $display("FAIL cpl_hold: got valid=%b %h required valid=1 %h", cpl_valid, cur, prev);
                    end
                end
                if (cpl_valid && cpl_ready) begin
                    n_checks++;
                    if (exp_cpl_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL cpl_extra: got %h required no descriptor", cur);
                    end else begin
                        if (cur !== exp_cpl_q[0]) begin
                            n_fail++;
                            $display("FAIL cpl_desc: got addr_low=%h len=%0d bytes=%0d last=%b (%h) required addr_low=%h len=%0d bytes=%0d last=%b (%h)",
                                     cpl_addr_low, cpl_len, cpl_bytes, cpl_last, cur,
                                     exp_cpl_q[0][58:52], exp_cpl_q[0][51:42], exp_cpl_q[0][41:30], exp_cpl_q[0][29], exp_cpl_q[0]);
                        end
                        void'(exp_cpl_q.pop_front());
                    end
                end
                pend = cpl_valid && !cpl_ready;
                prev = cur;
            end
        end
    end

    // Reference model: walk the request in bytes/DW and list every AR burst and completion.
    task automatic model_req(input logic [31:0] addr, input logic [9:0] len, input logic [3:0] bef,
                             input logic [3:0] bel, input logic [7:0] tag, input logic [15:0] src,
                             input logic [1:0] attr, input logic [2:0] tc, input logic [2:0] mps);
        int n, lead, hi, total, csz, rem, span, b;
        logic [3:0]  be_end;
        logic [31:0] a, cur_byte, end_byte, nbytes;
        logic [6:0]  alow;
        n = (len == 0) ? 1024 : int'(len);
        be_end = (n == 1) ? bef : bel;
        lead = 0;
        for (int i = 3; i >= 0; i--) if (bef[i]) lead = i;
        hi = 3;
        for (int i = 0; i < 4; i++) if (be_end[i]) hi = i;
        if (n == 1 && bef == 0) total = 1;
        else total = n * 4 - lead - (3 - hi);
        csz = 128 << mps;
        if (csz > MAX_SIZE) csz = MAX_SIZE;

        a = addr;
        rem = n;
        while (rem > 0) begin
            b = rem;
            if (b > 16) b = 16;
            if (b > (4096 - int'(a[11:0])) / 4) b = (4096 - int'(a[11:0])) / 4;
            exp_ar_q.push_back({a, LEN'(b - 1)});
            a = a + 32'(b * 4);
            rem -= b;
        end

        a = addr;
        rem = n;
        end_byte = addr + 32'(lead) + 32'(total);
        while (rem > 0) begin
            span = (csz - (int'(a[11:0]) % csz)) / 4;
            if (span > rem) span = rem;
            cur_byte = (rem == n) ? a + 32'(lead) : a;
            nbytes = end_byte - cur_byte;
            alow = cur_byte[6:0];
            exp_cpl_q.push_back({alow, 10'(span), nbytes[11:0], (rem == span), tag, src, attr, tc});
            a = a + 32'(span * 4);
            rem -= span;
        end
    endtask

    task automatic send_req(input logic [31:0] addr, input logic [9:0] len, input logic [3:0] bef,
                            input logic [3:0] bel, input logic [2:0] mps, output logic timed_out);
        logic [7:0]  tag;
        logic [15:0] src;
        logic [1:0]  attr;
        logic [2:0]  tc;
        int waited;
        tag  = 8'($urandom);
        src  = 16'($urandom);
        attr = 2'($urandom);
        tc   = 3'($urandom);
        model_req(addr, len, bef, bel, tag, src, attr, tc, mps);
        @(posedge clk);
        #1;
        waited = 0;
        while (!tlp_ready && waited < 5000) begin
            @(posedge clk);
            #1;
            waited++;
        end
        timed_out = !tlp_ready;
        tlp_valid    = 1'b1;
        tlp_addr     = addr[31:2];
        tlp_len      = len;
        tlp_be_first = bef;
        tlp_be_last  = bel;
        tlp_tag      = tag;
        tlp_src_id   = src;
        tlp_attr     = attr;
        tlp_tc       = tc;
        max_payload  = mps;
        @(posedge clk);
        #1;
        tlp_valid = 1'b0;
    endtask

    task automatic wait_idle(output logic timed_out);
        int waited;
        waited = 0;
        while ((exp_ar_q.size() != 0 || exp_cpl_q.size() != 0 || !tlp_ready) && waited < 5000) begin
            @(posedge clk);
            #1;
            waited++;
        end
        timed_out = (waited >= 5000);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({tlp_ready, axi_ar_valid, cpl_valid, dbg_busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_state: got ready/ar/cpl/busy=%b required 0000",
                     {tlp_ready, axi_ar_valid, cpl_valid, dbg_busy});
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (tlp_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b required 1", tlp_ready);
        end
    endtask

    task automatic run_directed(input string name, input logic [31:0] addr, input logic [9:0] len,
                                input logic [3:0] bef, input logic [3:0] bel, input logic [2:0] mps);
        logic to_send, to_idle;
        ar_rand = 1'b0; cpl_rand = 1'b0;
        ar_force = 1'b0; cpl_force = 1'b0;
        repeat (2) @(posedge clk);
        send_req(addr, len, bef, bel, mps, to_send);
        @(negedge clk);
        n_checks++;
        if ({to_send, tlp_ready, axi_ar_valid, cpl_valid, dbg_busy} !== 5'b00111) begin
            n_fail++;
            $display("FAIL %s_latency: got timeout/ready/ar/cpl/busy=%b required 00111", name,
                     {to_send, tlp_ready, axi_ar_valid, cpl_valid, dbg_busy});
        end
        ar_force = 1'b1; cpl_force = 1'b1;
        wait_idle(to_idle);
        n_checks++;
        if (to_idle || axi_ar_valid || cpl_valid) begin
            n_fail++;
            $display("FAIL %s_done: got timeout=%b ar=%b cpl=%b left ar=%0d cpl=%0d required all 0",
                     name, to_idle, axi_ar_valid, cpl_valid, exp_ar_q.size(), exp_cpl_q.size());
        end
    endtask

    task automatic test_backpressure();
        logic to_send, to_idle, ready_seen;
        ar_rand = 1'b0; cpl_rand = 1'b0;
        ar_force = 1'b0; cpl_force = 1'b1;
        repeat (2) @(posedge clk);
        send_req(32'h0000_2000, 10'd64, 4'hF, 4'hF, 3'd0, to_send);
        ready_seen = to_send;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tlp_ready !== 1'b0) ready_seen = 1'b1;
        end
        n_checks++;
        if (ready_seen) begin
            n_fail++;
            $display("FAIL bp_tlp_ready: got ready during AR stall required 0");
        end
        n_checks++;
        if (exp_cpl_q.size() != 0 || cpl_valid !== 1'b0 || axi_ar_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_cpl_drain: got cpl left=%0d cpl_valid=%b ar_valid=%b required 0 0 1",
                     exp_cpl_q.size(), cpl_valid, axi_ar_valid);
        end
        ar_force = 1'b1;
        wait_idle(to_idle);
        n_checks++;
        if (to_idle) begin
            n_fail++;
            $display("FAIL bp_done: got timeout left ar=%0d required 0", exp_ar_q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic to_send;
        ar_rand = 1'b0; cpl_rand = 1'b0;
        ar_force = 1'b0; cpl_force = 1'b0;
        repeat (2) @(posedge clk);
        send_req(32'h0000_3000, 10'd100, 4'hF, 4'hF, 3'd1, to_send);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({to_send, tlp_ready, axi_ar_valid, cpl_valid, dbg_busy} !== 5'b00000) begin
            n_fail++;
            $display("FAIL mid_reset: got timeout/ready/ar/cpl/busy=%b required 00000",
                     {to_send, tlp_ready, axi_ar_valid, cpl_valid, dbg_busy});
        end
        exp_ar_q.delete();
        exp_cpl_q.delete();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        run_directed("after_reset", 32'h0000_0FF0, 10'd9, 4'hC, 4'h3, 3'd0);
    endtask

    task automatic test_random();
        logic to_send, to_idle;
        logic [31:0] addr;
        logic [9:0]  len;
        logic [3:0]  bef, bel;
        ar_rand = 1'b1; cpl_rand = 1'b1;
        for (int k = 0; k < 25; k++) begin
            addr = $urandom & 32'hFFFF_FFFC;
            case ($urandom_range(0, 3))
                0: len = 10'd1;
                1: len = 10'($urandom_range(2, 40));
                2: len = 10'($urandom_range(41, 1023));
                default: len = 10'($urandom_range(0, 3));
            endcase
            if (len == 10'd1) begin
                bef = 4'($urandom);
                bel = 4'd0;
            end else begin
                bef = 4'($urandom_range(1, 15));
                bel = 4'($urandom_range(1, 15));
            end
            // back-to-back: the next request is offered as soon as the DUT idles
            send_req(addr, len, bef, bel, 3'($urandom_range(0, 5)), to_send);
            n_checks++;
            if (to_send) begin
                n_fail++;
                $display("FAIL random_accept_%0d: got no tlp_ready required ready", k);
            end
        end
        wait_idle(to_idle);
        n_checks++;
        if (to_idle) begin
            n_fail++;
            $display("FAIL random_done: got timeout left ar=%0d cpl=%0d required 0", exp_ar_q.size(), exp_cpl_q.size());
        end
        ar_rand = 1'b0; cpl_rand = 1'b0;
    endtask

    initial begin
        test_reset();
        run_directed("single_dw", 32'h0000_1000, 10'd1, 4'hF, 4'h0, 3'd0);
        run_directed("unaligned", 32'h0000_1038, 10'd32, 4'hE, 4'h7, 3'd0);
        run_directed("max_len", 32'h0000_0000, 10'd0, 4'hF, 4'hF, 3'd2);
        run_directed("clip_size", 32'h0000_0FC0, 10'd200, 4'h8, 4'h1, 3'd5);
        run_directed("zero_len", 32'h0000_0044, 10'd1, 4'h0, 4'h0, 3'd0);
        run_directed("wrap_addr", 32'hFFFF_FFF0, 10'd8, 4'hF, 4'hF, 3'd3);
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
